// File: rtl/vga_params_pkg.sv
// vga_params: shared 640x480@60 timing constants and a span helper for the scan controller and renderer
package vga_params;
    localparam int H_ACTIVE  = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_ACTIVE  = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int SNAP_LINE = V_ACTIVE;
    localparam int ADDR_W    = 19;

    function automatic logic in_span(input logic [9:0] c, input int lo, input int len);
        return c >= 10'(lo) && c < 10'(lo + len);
    endfunction
endpackage

// File: rtl/vga_scan_controller_timing_gen.sv
// vga_timing_gen: h/v scan counters with active, sync, snapshot and end-of-frame decode
// ports: i_clk/i_rst clock and async active-high reset; o_active visible pixel;
//        o_hs_n/o_vs_n active-low syncs; o_snap first pixel of the snapshot line; o_eof last pixel of frame
module vga_timing_gen
    import vga_params::*;
#(
    parameter int HA = H_ACTIVE,
    parameter int HF = H_FP,
    parameter int HS = H_SYNC,
    parameter int HB = H_BP,
    parameter int VA = V_ACTIVE,
    parameter int VF = V_FP,
    parameter int VS = V_SYNC,
    parameter int VB = V_BP,
    parameter int SNAP = SNAP_LINE
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_active,
    output logic o_hs_n,
    output logic o_vs_n,
    output logic o_snap,
    output logic o_eof
);
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic [9:0] r_h, r_v;
    logic       w_h_end, w_v_end;

    assign w_h_end = r_h == 10'(HT - 1);
    assign w_v_end = r_v == 10'(VT - 1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_h <= '0;
            r_v <= '0;
        end else begin
            r_h <= w_h_end ? '0 : r_h + 10'd1;
            if (w_h_end) r_v <= w_v_end ? '0 : r_v + 10'd1;
        end
    end

    assign o_active = r_h < 10'(HA) && r_v < 10'(VA);
    assign o_hs_n   = !in_span(r_h, HA + HF, HS);
    assign o_vs_n   = !in_span(r_v, VA + VF, VS);
    assign o_snap   = r_h == '0 && r_v == 10'(SNAP);
    assign o_eof    = w_h_end && w_v_end;
endmodule

// File: rtl/vga_scan_controller.sv
// vga_scan_controller: VGA scan-out with linear pixel address, frame-stable game snapshot and registered pins
// ports: clock/reset pixel clock and async active-high reset; field_in/score_in live game state;
//        bgr_data_raw renderer colour for ADDR {B,G,R}; ADDR linear pixel address (0 in blanking);
//        field/score snapshot to renderer; vga_r/g/b, vga_hs/vs (active-low), vga_blank_n registered pins;
//        frame_done one-cycle pulse while the snapshot is taken
module vga_scan_controller
    import vga_params::*;
#(
    parameter int HA = H_ACTIVE,
    parameter int HF = H_FP,
    parameter int HS = H_SYNC,
    parameter int HB = H_BP,
    parameter int VA = V_ACTIVE,
    parameter int VF = V_FP,
    parameter int VS = V_SYNC,
    parameter int VB = V_BP,
    parameter int SNAP = SNAP_LINE
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [399:0]      field_in,
    input  logic [31:0]       score_in,
    input  logic [23:0]       bgr_data_raw,
    output logic [ADDR_W-1:0] ADDR,
    output logic [399:0]      field,
    output logic [31:0]       score,
    output logic [7:0]        vga_r,
    output logic [7:0]        vga_g,
    output logic [7:0]        vga_b,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              vga_blank_n,
    output logic              frame_done
);
    logic              w_active, w_hs_n, w_vs_n, w_snap, w_eof;
    logic [ADDR_W-1:0] r_addr;

    vga_timing_gen #(
        .HA(HA), .HF(HF), .HS(HS), .HB(HB),
        .VA(VA), .VF(VF), .VS(VS), .VB(VB),
        .SNAP(SNAP)
    ) u_timing (
        .i_clk   (clock),
        .i_rst   (reset),
        .o_active(w_active),
        .o_hs_n  (w_hs_n),
        .o_vs_n  (w_vs_n),
        .o_snap  (w_snap),
        .o_eof   (w_eof)
    );

    // running address replaces row*width+col; it holds through blanking so each line continues where the last ended
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_addr      <= '0;
            field       <= '0;
            score       <= '0;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
        end else begin
            r_addr <= w_eof ? '0 : w_active ? r_addr + 1'b1 : r_addr;
            if (w_snap) begin
                field <= field_in;
                score <= score_in;
            end
            {vga_b, vga_g, vga_r} <= w_active ? bgr_data_raw : '0;
            vga_hs      <= w_hs_n;
            vga_vs      <= w_vs_n;
            vga_blank_n <= w_active;
        end
    end

    assign ADDR       = w_active ? r_addr : '0;
    assign frame_done = w_snap;
endmodule

// File: tb/tb_vga_scan_controller.sv
// tb_vga_scan_controller: randomized scoreboard bench for full-size and reduced-geometry scan controllers
module tb_vga_scan_controller;
    logic         clk = 1'b0;
    logic         rst [2];
    logic [399:0] fin [2], fo [2];
    logic [31:0]  sin [2], so [2];
    logic [23:0]  bgr [2];
    logic [18:0]  addr [2];
    logic [7:0]   vr [2], vg [2], vb [2];
    logic         hs [2], vs [2], bl [2], fd [2];
    int           n_cmp = 0, n_fail = 0;

    int h_act [2] = '{640, 16};
    int h_fp  [2] = '{16, 2};
    int h_sy  [2] = '{96, 4};
    int h_bp  [2] = '{48, 3};
    int v_act [2] = '{480, 6};
    int v_fp  [2] = '{10, 2};
    int v_sy  [2] = '{2, 2};
    int v_bp  [2] = '{33, 1};
    int pr_h  [4] = '{0, 639, 0, 700};
    int pr_v  [4] = '{0, 0, 1, 10};
    int pr_a  [4] = '{0, 639, 640, 0};

    always #20 clk = ~clk;

    vga_scan_controller u_dut0 (
        .clock(clk), .reset(rst[0]), .field_in(fin[0]), .score_in(sin[0]), .bgr_data_raw(bgr[0]),
        .ADDR(addr[0]), .field(fo[0]), .score(so[0]), .vga_r(vr[0]), .vga_g(vg[0]), .vga_b(vb[0]),
        .vga_hs(hs[0]), .vga_vs(vs[0]), .vga_blank_n(bl[0]), .frame_done(fd[0])
    );

    vga_scan_controller #(
        .HA(16), .HF(2), .HS(4), .HB(3), .VA(6), .VF(2), .VS(2), .VB(1), .SNAP(6)
    ) u_dut1 (
        .clock(clk), .reset(rst[1]), .field_in(fin[1]), .score_in(sin[1]), .bgr_data_raw(bgr[1]),
        .ADDR(addr[1]), .field(fo[1]), .score(so[1]), .vga_r(vr[1]), .vga_g(vg[1]), .vga_b(vb[1]),
        .vga_hs(hs[1]), .vga_vs(vs[1]), .vga_blank_n(bl[1]), .frame_done(fd[1])
    );

    function automatic int ht(int d);
        return h_act[d] + h_fp[d] + h_sy[d] + h_bp[d];
    endfunction

    function automatic int vt(int d);
        return v_act[d] + v_fp[d] + v_sy[d] + v_bp[d];
    endfunction

    function automatic int hp(int d, int c);
        return c % ht(d);
    endfunction

    function automatic int vp(int d, int c);
        return (c / ht(d)) % vt(d);
    endfunction

    function automatic bit act(int d, int c);
        return c >= 0 && hp(d, c) < h_act[d] && vp(d, c) < v_act[d];
    endfunction

    function automatic bit hsx(int d, int c);
        int h;
        if (c < 0) return 1'b1;
        h = hp(d, c);
        return !(h >= h_act[d] + h_fp[d] && h < h_act[d] + h_fp[d] + h_sy[d]);
    endfunction

    function automatic bit vsx(int d, int c);
        int v;
        if (c < 0) return 1'b1;
        v = vp(d, c);
        return !(v >= v_act[d] + v_fp[d] && v < v_act[d] + v_fp[d] + v_sy[d]);
    endfunction

    task automatic restart(input int d);
        @(negedge clk);
        rst[d] = 1'b1;
        @(negedge clk);
        rst[d] = 1'b0;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                bgr[d] = 24'($urandom);
                sin[d] = $urandom;
                for (int j = 0; j < 400; j++) fin[d][j] = 1'($urandom);
                #1;
                n_cmp++;
                if ({addr[d], vb[d], vg[d], vr[d], hs[d], vs[d], bl[d], fd[d]} !== {19'd0, 24'd0, 4'b1100}) begin
                    n_fail++;
                    $display("FAIL reset_pins d%0d: got addr=%0d bgr=%h hs=%b vs=%b blank=%b fd=%b want 0/0/1/1/0/0",
                             d, addr[d], {vb[d], vg[d], vr[d]}, hs[d], vs[d], bl[d], fd[d]);
                end
                n_cmp++;
                if ({fo[d], so[d]} !== '0) begin
                    n_fail++;
                    $display("FAIL reset_snapshot d%0d: got score=%h field!=0 want 0", d, so[d]);
                end
            end
        end
    endtask

    task automatic test_scan(input int d, input int n);
        logic [399:0] ef = '0;
        logic [31:0]  es = '0;
        logic [23:0]  pc = '0;
        bit p_bl = 1'b0, p_hs = 1'b1, p_vs = 1'b1, vs_prev = 1'b1;
        int bl_n = 0, hs_n = 0, hs_run = 0, vs_n = 0, vs_low = 0, fd_n = 0, f0 = n_fail, fr;
        for (int i = 0; i < n && n_fail - f0 < 20; i++) begin
            int h, v, ea;
            h = hp(d, i);
            v = vp(d, i);
            ea = act(d, i) ? v * h_act[d] + h : 0;
            bgr[d] = 24'($urandom);
            if ((h == 0 && v == v_act[d]) || $urandom_range(0, 40) == 0) begin
                for (int j = 0; j < 400; j++) fin[d][j] = 1'($urandom);
                sin[d] = $urandom;
            end
            n_cmp++;
            if (addr[d] !== 19'(ea)) begin
                n_fail++;
                $display("FAIL addr d%0d (%0d,%0d): got %0d want %0d", d, h, v, addr[d], ea);
            end
            for (int k = 0; k < 4; k++)
                if (d == 0 && h == pr_h[k] && v == pr_v[k]) begin
                    n_cmp++;
                    if (addr[d] !== 19'(pr_a[k])) begin
                        n_fail++;
                        $display("FAIL addr_probe (%0d,%0d): got %0d want %0d", h, v, addr[d], pr_a[k]);
                    end
                end
            n_cmp++;
            if (fd[d] !== (h == 0 && v == v_act[d])) begin
                n_fail++;
                $display("FAIL frame_done d%0d (%0d,%0d): got %b", d, h, v, fd[d]);
            end
            n_cmp++;
            if ({vb[d], vg[d], vr[d]} !== pc) begin
                n_fail++;
                $display("FAIL colour d%0d (%0d,%0d): got %h want %h", d, h, v, {vb[d], vg[d], vr[d]}, pc);
            end
            n_cmp++;
            if ({hs[d], vs[d], bl[d]} !== {p_hs, p_vs, p_bl}) begin
                n_fail++;
                $display("FAIL sync_blank d%0d (%0d,%0d): got hs/vs/blank=%b%b%b want %b%b%b",
                         d, h, v, hs[d], vs[d], bl[d], p_hs, p_vs, p_bl);
            end
            n_cmp++;
            if (so[d] !== es || fo[d] !== ef) begin
                n_fail++;
                $display("FAIL snapshot d%0d (%0d,%0d): got score=%h want %h field_ok=%b", d, h, v, so[d], es, fo[d] === ef);
            end
            if (bl[d]) bl_n++;
            if (!hs[d]) hs_run++;
            else if (hs_run > 0) begin
                n_cmp++;
                if (hs_run != h_sy[d]) begin
                    n_fail++;
                    $display("FAIL hs_width d%0d: got %0d want %0d", d, hs_run, h_sy[d]);
                end
                hs_n++;
                hs_run = 0;
            end
            if (!vs[d]) vs_low++;
            if (!vs[d] && vs_prev) vs_n++;
            vs_prev = vs[d];
            fd_n += int'(fd[d]);
            if (h == 0 && v == v_act[d]) begin
                ef = fin[d];
                es = sin[d];
            end
            pc = act(d, i) ? bgr[d] : 24'h0;
            p_bl = act(d, i);
            p_hs = hsx(d, i);
            p_vs = vsx(d, i);
            @(negedge clk);
        end
        if (n % ht(d) == 0) begin
            n_cmp++;
            if (hs_n != n / ht(d)) begin
                n_fail++;
                $display("FAIL hs_pulses d%0d: got %0d want %0d", d, hs_n, n / ht(d));
            end
        end
        if (n % (ht(d) * vt(d)) == 0) begin
            fr = n / (ht(d) * vt(d));
            n_cmp++;
            if (bl_n != fr * h_act[d] * v_act[d] || vs_n != fr || vs_low != fr * v_sy[d] * ht(d) || fd_n != fr) begin
                n_fail++;
                $display("FAIL frame_totals d%0d: got blank=%0d vs=%0d vs_low=%0d fd=%0d want %0d/%0d/%0d/%0d",
                         d, bl_n, vs_n, vs_low, fd_n, fr * h_act[d] * v_act[d], fr, fr * v_sy[d] * ht(d), fr);
            end
        end
    endtask

    task automatic test_color_const();
        bit pa = 1'b0;
        restart(1);
        bgr[1] = 24'h112233;
        for (int i = 0; i <= ht(1) * vt(1); i++) begin
            n_cmp++;
            if ({vb[1], vg[1], vr[1]} !== (pa ? 24'h112233 : 24'h0)) begin
                n_fail++;
                $display("FAIL const_colour cyc %0d: got b=%h g=%h r=%h want active=%b", i, vb[1], vg[1], vr[1], pa);
            end
            pa = act(1, i);
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        restart(1);
        bgr[1] = 24'hABCDEF;
        sin[1] = $urandom | 32'd1;
        for (int j = 0; j < 400; j++) fin[1][j] = 1'($urandom);
        repeat (ht(1) * vt(1) + 3 * ht(1) + 8) @(negedge clk);
        #3 rst[1] = 1'b1;
        #1;
        for (int c = 0; c < 4; c++) begin
            n_cmp++;
            if ({addr[1], vb[1], vg[1], vr[1], hs[1], vs[1], bl[1], fd[1]} !== {19'd0, 24'd0, 4'b1100}) begin
                n_fail++;
                $display("FAIL midreset_pins step %0d: got addr=%0d bgr=%h hs=%b vs=%b blank=%b fd=%b",
                         c, addr[1], {vb[1], vg[1], vr[1]}, hs[1], vs[1], bl[1], fd[1]);
            end
            n_cmp++;
            if ({fo[1], so[1]} !== '0) begin
                n_fail++;
                $display("FAIL midreset_snapshot step %0d: got score=%h want 0", c, so[1]);
            end
            if (c < 3) @(negedge clk);
        end
        rst[1] = 1'b0;
        test_scan(1, ht(1) * vt(1));
    endtask

    task automatic test_wrap();
        restart(1);
        bgr[1] = 24'h5A5A5A;
        repeat (ht(1) * vt(1) - 1) @(negedge clk);
        n_cmp++;
        if ({addr[1], fd[1]} !== 20'd0) begin
            n_fail++;
            $display("FAIL wrap_last: got addr=%0d fd=%b want 0/0", addr[1], fd[1]);
        end
        @(negedge clk);
        n_cmp++;
        if ({addr[1], bl[1], hs[1]} !== {19'd0, 2'b01}) begin
            n_fail++;
            $display("FAIL wrap_origin: got addr=%0d blank=%b hs=%b want 0/0/1", addr[1], bl[1], hs[1]);
        end
        @(negedge clk);
        n_cmp++;
        if ({addr[1], bl[1]} !== {19'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL wrap_next: got addr=%0d blank=%b want 1/1", addr[1], bl[1]);
        end
    endtask

    initial begin
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        for (int d = 0; d < 2; d++) begin
            fin[d] = '0;
            sin[d] = '0;
            bgr[d] = '0;
        end
        test_reset();
        restart(0);
        test_scan(0, 800 * 12);
        rst[0] = 1'b1;
        restart(1);
        test_scan(1, 3 * ht(1) * vt(1));
        test_color_const();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
